serdesphy_rx_deser_align: RTL and testbench

Receive-side serial-to-parallel converter and word aligner. It sits directly downstream of the analog CDR. It samples the recovered serial bit stream on the 240 MHz recovered clock while the CDR reports lock, hunts for a programmable sync word and confirms word alignment. Once aligned, it delivers 16-bit parallel words with a one-cycle valid strobe to the RX PCS/elastic buffer.

---
 rtl/serdesphy_rx_pkg.sv | 22 ++
 rtl/serdesphy_rx_shifter.sv | 46 ++++
 rtl/serdesphy_rx_deser_align.sv | 156 +++++++++++++++
 tb/tb_serdesphy_rx_deser_align.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_rx_pkg.sv
// Shared definitions for the RX deserializer / word aligner.
//   - rx_state_t    : aligner FSM states
//   - WORD_W_DEF    : default parallel word width
//   - SYNC_WORD_DEF : default alignment pattern (MSB is the first bit on the wire)
//   - sat_inc8      : saturating 8-bit increment used by the loss counter
package serdesphy_rx_pkg;

    localparam int          WORD_W_DEF    = 16;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hBC3C;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        VERIFY,
        ALIGNED
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serdesphy_rx_shifter.sv
// Serial shift register and bit counter for the RX aligner.
// Ports:
//   clk, rst      : recovered clock, asynchronous active-high reset
//   sample        : enable && cdr_lock; low clears the register and counter
//   load_zero     : force bit_cnt to 0 on this edge (hunt match = word boundary)
//   serial_data   : recovered serial bit
//   nxt           : word formed by the current sample, MSB = earliest bit
//   bit_cnt       : position of the bit being sampled within the word
//   boundary      : this sampled edge completes a word
module serdesphy_rx_shifter
    import serdesphy_rx_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    localparam int CNT_W = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample,
    input  logic              load_zero,
    input  logic              serial_data,
    output logic [WORD_W-1:0] nxt,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              boundary
);

    // Only the most recent WORD_W-1 bits need storing; the new bit completes
    // the compare word combinationally.
    logic [WORD_W-2:0] sh;

    assign nxt      = {sh, serial_data};
    assign boundary = sample && (bit_cnt == CNT_W'(WORD_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (!sample) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else begin
            sh      <= nxt[WORD_W-2:0];
            bit_cnt <= (load_zero || boundary) ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serdesphy_rx_deser_align.sv
// RX serial-to-parallel converter and word aligner.
// Hunts for SYNC_WORD in the recovered bit stream, confirms alignment over
// SYNC_CONFIRM on-boundary sync words, then emits every aligned word with a
// one-cycle data_valid strobe. Alignment is dropped on lock/enable loss or
// after MAX_GAP consecutive words without a sync word.
// Ports:
//   clk_240m_rx    : recovered clock (sole clock)
//   rst            : asynchronous active-high reset
//   enable         : block enable; low forces IDLE
//   cdr_lock       : CDR lock; low forces IDLE
//   serial_data    : recovered serial bit
//   parallel_data  : aligned word, MSB = earliest bit
//   data_valid     : one-cycle strobe per emitted word
//   aligned        : high while in ALIGNED
//   bit_offset     : bit_cnt phase captured at the last hunt match
//   align_loss_cnt : saturating count of exits from ALIGNED
module serdesphy_rx_deser_align
    import serdesphy_rx_pkg::*;
#(
    parameter int                WORD_W       = WORD_W_DEF,
    parameter logic [WORD_W-1:0] SYNC_WORD    = WORD_W'(SYNC_WORD_DEF),
    parameter int                SYNC_CONFIRM = 3,
    parameter int                MAX_GAP      = 255
) (
    input  logic              clk_240m_rx,
    input  logic              rst,
    input  logic              enable,
    input  logic              cdr_lock,
    input  logic              serial_data,
    output logic [WORD_W-1:0] parallel_data,
    output logic              data_valid,
    output logic              aligned,
    output logic [3:0]        bit_offset,
    output logic [7:0]        align_loss_cnt
);

    localparam int CNT_W = $clog2(WORD_W);

    rx_state_t         state;
    logic [2:0]        confirm;
    logic [7:0]        gap;
    logic              sample;
    logic              sync_hit;
    logic              load_zero;
    logic              boundary;
    logic [WORD_W-1:0] nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        confirm_inc;
    logic [7:0]        gap_inc;

    assign sample      = enable && cdr_lock;
    assign sync_hit    = (nxt == SYNC_WORD);
    // A hunt match re-phases the bit counter so the matching edge becomes a boundary.
    assign load_zero   = sample && (state == HUNT) && sync_hit;
    assign confirm_inc = confirm + 3'd1;
    assign gap_inc     = gap + 8'd1;

    serdesphy_rx_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk         (clk_240m_rx),
        .rst         (rst),
        .sample      (sample),
        .load_zero   (load_zero),
        .serial_data (serial_data),
        .nxt         (nxt),
        .bit_cnt     (bit_cnt),
        .boundary    (boundary)
    );

    always_ff @(posedge clk_240m_rx or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            confirm        <= '0;
            gap            <= '0;
            parallel_data  <= '0;
            data_valid     <= 1'b0;
            aligned        <= 1'b0;
            bit_offset     <= '0;
            align_loss_cnt <= '0;
        end else begin
            data_valid <= 1'b0;
            if (!sample) begin
                // Lock/enable loss wins over everything; a partial word is dropped.
                state   <= IDLE;
                aligned <= 1'b0;
                confirm <= '0;
                gap     <= '0;
                if (state == ALIGNED) begin
                    align_loss_cnt <= sat_inc8(align_loss_cnt);
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= HUNT;
                    end
                    HUNT: begin
                        if (sync_hit) begin
                            bit_offset <= 4'(bit_cnt);
                            confirm    <= 3'd1;
                            if (SYNC_CONFIRM == 1) begin
                                state         <= ALIGNED;
                                aligned       <= 1'b1;
                                gap           <= '0;
                                parallel_data <= nxt;
                                data_valid    <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (boundary) begin
                            if (sync_hit) begin
                                confirm <= confirm_inc;
                                if (confirm_inc == 3'(SYNC_CONFIRM)) begin
                                    // The confirming sync word is emitted as data.
                                    state         <= ALIGNED;
                                    aligned       <= 1'b1;
                                    gap           <= '0;
                                    parallel_data <= nxt;
                                    data_valid    <= 1'b1;
                                end
                            end else begin
                                state   <= HUNT;
                                confirm <= '0;
                            end
                        end
                    end
                    ALIGNED: begin
                        if (boundary) begin
                            parallel_data <= nxt;
                            data_valid    <= 1'b1;
                            if (sync_hit) begin
                                gap <= '0;
                            end else if (gap_inc == 8'(MAX_GAP)) begin
                                // The word at the final gap boundary still goes out.
                                state          <= HUNT;
                                aligned        <= 1'b0;
                                gap            <= '0;
                                confirm        <= '0;
                                align_loss_cnt <= sat_inc8(align_loss_cnt);
                            end else begin
                                gap <= gap_inc;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serdesphy_rx_deser_align.sv
// Directed bench for serdesphy_rx_deser_align (MAX_GAP = 4, SYNC_CONFIRM = 3).
// Stimulus pushes each expected emitted word into a queue; a negedge monitor
// pops and compares whenever data_valid is high.
module tb_serdesphy_rx_deser_align;

    localparam logic [15:0] SYNC = 16'hBC3C;

    logic        clk_240m_rx = 1'b0;
    logic        rst;
    logic        enable;
    logic        cdr_lock;
    logic        serial_data;
    logic [15:0] parallel_data;
    logic        data_valid;
    logic        aligned;
    logic [3:0]  bit_offset;
    logic [7:0]  align_loss_cnt;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_q[$];

    always #2 clk_240m_rx = ~clk_240m_rx;

    serdesphy_rx_deser_align #(
        .WORD_W       (16),
        .SYNC_WORD    (SYNC),
        .SYNC_CONFIRM (3),
        .MAX_GAP      (4)
    ) dut (
        .clk_240m_rx    (clk_240m_rx),
        .rst            (rst),
        .enable         (enable),
        .cdr_lock       (cdr_lock),
        .serial_data    (serial_data),
        .parallel_data  (parallel_data),
        .data_valid     (data_valid),
        .aligned        (aligned),
        .bit_offset     (bit_offset),
        .align_loss_cnt (align_loss_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every emitted word must match the oldest pending one.
    always @(negedge clk_240m_rx) begin
        if (!rst && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %h with no word pending", parallel_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                $display("word %h expected %h", parallel_data, e);
                check("word", {16'h0, parallel_data}, {16'h0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk_240m_rx);
        #1;
    endtask

    // Send the top n bits of w, MSB first.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 15; i >= 16 - n; i--) begin
            serial_data = w[i];
            tick();
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        send_bits(w, 16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_loss;
        rst         = 1'b1;
        enable      = 1'b1;
        cdr_lock    = 1'b0;
        serial_data = 1'b0;
        repeat (3) tick();
        check("rst_parallel_data", {16'h0, parallel_data}, 32'h0);
        check("rst_data_valid", {31'h0, data_valid}, 32'h0);
        check("rst_aligned", {31'h0, aligned}, 32'h0);
        check("rst_bit_offset", {28'h0, bit_offset}, 32'h0);
        check("rst_loss_cnt", {24'h0, align_loss_cnt}, 32'h0);

        // Unlocked: random data must be ignored.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            serial_data = 1'($urandom_range(0, 1));
            tick();
        end
        check("idle_aligned", {31'h0, aligned}, 32'h0);
        check("idle_bit_offset", {28'h0, bit_offset}, 32'h0);
        check("idle_loss_cnt", {24'h0, align_loss_cnt}, 32'h0);

        // Acquisition: 5 filler bits, 3 sync words, then data.
        cdr_lock = 1'b1;
        send_bits(16'h0000, 5);
        send_word(SYNC);
        check("acq_aligned_1", {31'h0, aligned}, 32'h0);
        check("acq_bit_offset", {28'h0, bit_offset}, 32'd4);
        send_word(SYNC);
        check("acq_aligned_2", {31'h0, aligned}, 32'h0);
        exp_q.push_back(SYNC);
        send_word(SYNC);
        check("acq_aligned_3", {31'h0, aligned}, 32'h1);
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        check("acq_aligned_data", {31'h0, aligned}, 32'h1);

        // Gap loss: sync clears gap, then 4 non-sync words drop alignment.
        exp_q.push_back(SYNC);
        send_word(SYNC);
        exp_q.push_back(16'hA5A5);
        send_word(16'hA5A5);
        exp_q.push_back(16'h0F0F);
        send_word(16'h0F0F);
        exp_q.push_back(16'h1111);
        send_word(16'h1111);
        check("gap_aligned_3", {31'h0, aligned}, 32'h1);
        exp_q.push_back(16'h2222);
        send_word(16'h2222);
        check("gap_aligned_4", {31'h0, aligned}, 32'h0);
        check("gap_loss_cnt", {24'h0, align_loss_cnt}, 32'd1);

        // Verify failure: from HUNT, a lock drop does not count as a loss.
        cdr_lock = 1'b0;
        tick();
        check("hunt_drop_loss_cnt", {24'h0, align_loss_cnt}, 32'd1);
        cdr_lock = 1'b1;
        send_word(SYNC);
        check("vfy_bit_offset", {28'h0, bit_offset}, 32'd15);
        send_word(16'h0000);
        check("vfy_fail_aligned", {31'h0, aligned}, 32'h0);
        check("vfy_fail_loss_cnt", {24'h0, align_loss_cnt}, 32'd1);
        send_word(SYNC);
        send_word(SYNC);
        check("vfy_retry_aligned", {31'h0, aligned}, 32'h0);
        exp_q.push_back(SYNC);
        send_word(SYNC);
        check("vfy_retry_aligned_3", {31'h0, aligned}, 32'h1);

        // Lock drop after 7 bits of a word: no partial word, loss counted.
        send_bits(16'h1234, 7);
        cdr_lock = 1'b0;
        tick();
        check("drop_aligned", {31'h0, aligned}, 32'h0);
        check("drop_data_valid", {31'h0, data_valid}, 32'h0);
        check("drop_loss_cnt", {24'h0, align_loss_cnt}, 32'd2);
        cdr_lock = 1'b1;
        send_word(SYNC);
        send_word(SYNC);
        check("relock_aligned_2", {31'h0, aligned}, 32'h0);
        exp_q.push_back(SYNC);
        send_word(SYNC);
        check("relock_aligned_3", {31'h0, aligned}, 32'h1);
        check("relock_bit_offset", {28'h0, bit_offset}, 32'd15);

        // Saturation: 300 align/loss cycles.
        for (int i = 0; i < 300; i++) begin
            cdr_lock = 1'b0;
            tick();
            exp_loss = (3 + i > 255) ? 255 : 3 + i;
            check("sat_loss_cnt", {24'h0, align_loss_cnt}, 32'(exp_loss));
            cdr_lock = 1'b1;
            send_word(SYNC);
            send_word(SYNC);
            exp_q.push_back(SYNC);
            send_word(SYNC);
        end
        check("sat_final_aligned", {31'h0, aligned}, 32'h1);

        // Asynchronous reset mid-word.
        send_bits(16'h1234, 7);
        rst = 1'b1;
        #1;
        check("arst_aligned", {31'h0, aligned}, 32'h0);
        check("arst_loss_cnt", {24'h0, align_loss_cnt}, 32'h0);
        check("arst_bit_offset", {28'h0, bit_offset}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        send_word(SYNC);
        check("arst_resync_aligned", {31'h0, aligned}, 32'h0);
        repeat (3) tick();
        check("pending_words", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
